// File: rtl/vert_blur_if.sv
// Pixel stream bundle between the horizontal blur, the vertical blur stage
// and the write-back logic.
interface vert_blur_if;
  logic        frame_start;
  logic        vb_en;
  logic [2:0]  mode_vb;
  logic [31:0] data;
  logic [31:0] blur;
  logic        blur_valid;
  logic        frame_done;

  modport master (
    output frame_start, vb_en, mode_vb, data,
    input  blur, blur_valid, frame_done
  );

  modport slave (
    input  frame_start, vb_en, mode_vb, data,
    output blur, blur_valid, frame_done
  );
endinterface

// File: rtl/vert_blur.sv
// Vertical 4-tap box blur: averages each pixel with the three pixels above it
// using three line buffers; alpha is forced opaque in blur mode.
module vert_blur #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  vert_blur_if.slave bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [2:0]    MODE_BLUR = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q, col_eff;
  logic [RW-1:0] row_q, row_eff;
  logic          accept;
  logic          last_px;

  logic [31:0] lb0 [IMG_WIDTH];
  logic [31:0] lb1 [IMG_WIDTH];
  logic [31:0] lb2 [IMG_WIDTH];

  logic [31:0] m0, m1, m2;
  logic [9:0]  sum [3];
  logic [31:0] blur_px;
  logic        unused_bits;

  // frame_start wins over the stored position, so a pixel arriving with it
  // is taken as (0,0) of the new frame from any state.
  assign accept  = bus.vb_en && ((state_q == ACTIVE) || bus.frame_start);
  assign col_eff = bus.frame_start ? '0 : col_q;
  assign row_eff = bus.frame_start ? '0 : row_q;
  assign last_px = accept && (col_eff == COL_LAST) && (row_eff == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.frame_start) state_d = ACTIVE;
      ACTIVE:  if (last_px) state_d = DONE;
      DONE:    state_d = bus.frame_start ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_eff == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_q <= col_eff + CW'(1);
        row_q <= row_eff;
      end
    end else if (bus.frame_start) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

  // Buffers are never cleared; stale rows are hidden by the row mask below.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_eff] <= lb1[col_eff];
      lb1[col_eff] <= lb0[col_eff];
      lb0[col_eff] <= bus.data;
    end
  end

  assign m0 = (row_eff >= RW'(1)) ? lb0[col_eff] : '0;
  assign m1 = (row_eff >= RW'(2)) ? lb1[col_eff] : '0;
  assign m2 = (row_eff >= RW'(3)) ? lb2[col_eff] : '0;

  always_comb begin
    blur_px = 32'hff000000;
    for (int ch = 0; ch < 3; ch++) begin
      sum[ch] = {2'b00, bus.data[ch*8 +: 8]} + {2'b00, m0[ch*8 +: 8]}
              + {2'b00, m1[ch*8 +: 8]} + {2'b00, m2[ch*8 +: 8]};
      blur_px[ch*8 +: 8] = sum[ch][9:2];
    end
  end

  assign unused_bits = ^{m0[31:24], m1[31:24], m2[31:24],
                         sum[0][1:0], sum[1][1:0], sum[2][1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.blur       <= 32'hff000000;
      bus.blur_valid <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.blur_valid <= accept;
      bus.frame_done <= last_px;
      if (accept) begin
        bus.blur <= (bus.mode_vb == MODE_BLUR) ? blur_px : bus.data;
      end
    end
  end

endmodule

// File: tb/tb_vert_blur.sv
// Directed bench for vert_blur on a 4x4 frame; a frame-image model feeds a
// scoreboard queue that is drained as blur_valid pulses appear.
module tb_vert_blur;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  vert_blur_if bus();

  vert_blur #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [32:0] sb_q [$];
  logic [31:0] img [H][W];
  int          m_row, m_col;
  bit          m_active;
  logic [31:0] last_blur;
  logic [31:0] row_exp [4] = '{32'hff3f3f3f, 32'hff7f7f7f, 32'hffbfbfbf, 32'hffffffff};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_px(input int r, input int c,
                                           input logic [2:0] mode, input logic [31:0] d);
    logic [31:0] res;
    int s;
    if (mode != 3'b101) return d;
    res = 32'hff000000;
    for (int ch = 0; ch < 3; ch++) begin
      s = int'(d[ch*8 +: 8]);
      for (int k = 1; k <= 3; k++)
        if (r - k >= 0) s += int'(img[r-k][c][ch*8 +: 8]);
      res[ch*8 +: 8] = 8'(s / 4);
    end
    return res;
  endfunction

  task automatic apply_reset();
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.vb_en       = 1'b1;
    bus.mode_vb     = 3'b101;
    bus.data        = 32'hdeadbeef;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.vb_en = 1'b0;
    m_active  = 1'b0;
    m_row     = 0;
    m_col     = 0;
    last_blur = 32'hff000000;
    sb_q.delete();
    check_val("reset_blur", bus.blur, 32'hff000000);
    check_val("reset_valid", {31'b0, bus.blur_valid}, 32'd0);
    check_val("reset_done", {31'b0, bus.frame_done}, 32'd0);
  endtask

  // One clock of stimulus; the model decides acceptance and queues the result.
  task automatic step(input bit fs, input bit en, input logic [2:0] mode, input logic [31:0] d);
    bit          acc;
    bit          done;
    logic [31:0] e;
    logic [32:0] item;
    acc = en && (m_active || fs);
    e   = last_blur;
    if (fs) begin
      m_row    = 0;
      m_col    = 0;
      m_active = 1'b1;
    end
    if (acc) begin
      e    = model_px(m_row, m_col, mode, d);
      done = (m_row == H - 1) && (m_col == W - 1);
      img[m_row][m_col] = d;
      sb_q.push_back({done, e});
      if (m_col == W - 1) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
      if (done) m_active = 1'b0;
    end
    bus.frame_start = fs;
    bus.vb_en       = en;
    bus.mode_vb     = mode;
    bus.data        = d;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.vb_en       = 1'b0;
    check_val("valid", {31'b0, bus.blur_valid}, {31'b0, acc});
    if (bus.blur_valid) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_empty observed=valid expected=no_output");
      end
      if (sb_q.size() != 0) begin
        item = sb_q.pop_front();
        check_val("blur", bus.blur, item[31:0]);
        check_val("frame_done", {31'b0, bus.frame_done}, {31'b0, item[32]});
      end
    end else begin
      check_val("hold", bus.blur, last_blur);
      check_val("done_idle", {31'b0, bus.frame_done}, 32'd0);
    end
    last_blur = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.vb_en       = 1'b0;
    bus.mode_vb     = 3'b000;
    bus.data        = '0;
    apply_reset();

    // Idle, then strobes before arming must be ignored.
    step(0, 0, 3'b101, 32'h0);
    step(0, 0, 3'b101, 32'h0);
    step(0, 1, 3'b101, 32'hffffffff);
    step(0, 1, 3'b101, 32'hffffffff);

    // Full white frame in blur mode.
    step(1, 0, 3'b101, 32'h0);
    for (int i = 0; i < W * H; i++) begin
      step(0, 1, 3'b101, 32'hffffffff);
      check_val("white_row", bus.blur, row_exp[i / W]);
    end
    step(0, 1, 3'b101, 32'hffffffff);

    // Pass-through with frame_start and vb_en together from IDLE.
    step(1, 1, 3'b000, 32'h12345678);
    check_val("pass", bus.blur, 32'h12345678);

    // Abort that frame, then a ramp in column 0 with a stall and a mode flip.
    step(1, 0, 3'b101, 32'h0);
    for (int i = 0; i < W * H; i++) begin
      logic [31:0] d;
      d = (i % W == 0) ? 32'h00040404 * 32'((i / W) + 1) : $urandom;
      if (i == 9) step(0, 0, 3'b101, d);
      step(0, 1, (i == 6) ? 3'b000 : 3'b101, d);
      if (i == 12) check_val("col0_row3", bus.blur, 32'hff0a0a0a);
    end

    // Abort after 6 pixels by frame_start with a pixel.
    for (int i = 0; i < 6; i++) step(i == 0, 1, 3'b101, $urandom);
    step(1, 1, 3'b101, 32'hffffffff);
    check_val("abort_row0", bus.blur, 32'hff3f3f3f);
    for (int i = 1; i < W * H; i++) step(0, 1, 3'b101, 32'hffffffff);

    // Reset in the middle of row 2; strobes afterwards are ignored.
    step(1, 0, 3'b101, 32'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 3'b101, $urandom);
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 3'b101, $urandom);

    // Full frame, then re-arm with a pixel during DONE.
    step(1, 0, 3'b101, 32'h0);
    for (int i = 0; i < W * H; i++) step(0, 1, 3'b101, $urandom);
    step(1, 1, 3'b101, 32'h80808080);
    check_val("restart_from_done", bus.blur, 32'hff202020);
    step(0, 0, 3'b101, 32'h0);

    total++;
    assert (sb_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vert_blur.md
# vert_blur

Vertical blur stage placed directly downstream of the horizontal blur filter. It consumes the horizontally blurred ARGB pixel stream in raster order and stores the previous three rows in line buffers. For each accepted pixel it outputs the per-channel average of that pixel and the three pixels directly above it, which completes the separable blur before write-back.

## Interface
- IMG_WIDTH, 640, pixels per row; must be at least 2.
- IMG_HEIGHT, 480, rows per frame; must be at least 4.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- frame_start  input  1  one-cycle pulse; arms the block for a new frame.
- vb_en  input  1  pixel strobe; `data` is accepted on each rising edge where vb_en=1 and the state is ACTIVE.
- mode_vb  input  3  3'b101 selects blur; any other value selects pass-through.
- data  input  32  ARGB pixel from the horizontal blur: [31:24] A, [23:16] R, [15:8] G, [7:0] B.
- blur  output  32  registered result pixel.
- blur_valid  output  1  high for one cycle per accepted pixel, while `blur` holds that pixel's result.
- frame_done  output  1  one-cycle pulse, coincident with blur_valid for the last pixel of the frame.

## Operation
- State machine has three states: IDLE, ACTIVE, DONE.
  - IDLE goes to ACTIVE on frame_start. vb_en is ignored in IDLE.
  - ACTIVE goes to DONE when pixel (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.
  - DONE goes to IDLE unconditionally after one cycle, unless frame_start is high, in which case it goes to ACTIVE.
- Counters: col counts 0..IMG_WIDTH-1, row counts 0..IMG_HEIGHT-1.
  - On each accepted pixel, col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - frame_start clears both counters in any state.
- Line buffers: three arrays lb0, lb1, lb2, each IMG_WIDTH x 32 bits. lb0 holds the row above, lb1 two rows above, lb2 three rows above.
  - On accept at column c: lb2[c] <= lb1[c], lb1[c] <= lb0[c], lb0[c] <= data. All three shift in the same cycle.
- Row masking: lbK contributes only if row >= K+1; otherwise it contributes zero. Missing rows at the top of a frame therefore count as black. Buffer contents are never cleared.
- Blur mode, per channel R, G, B:
  - sum = data_ch + m0 + m1 + m2, computed as a 10-bit unsigned sum (max 1020, no overflow).
  - result = sum[9:2], i.e. floor(sum/4).
  - Output alpha is forced to 8'hff.
- Pass-through mode: blur <= data unchanged, including alpha. Line buffers still update, so the mode may change mid-frame.
- mode_vb is sampled with each accepted pixel. It is not latched per frame.
- frame_start asserted in ACTIVE aborts the current frame: counters go to 0, no frame_done is produced, and the block stays in ACTIVE.
- frame_start and vb_en high in the same cycle: the counters clear first, then that pixel is accepted as (0,0) of the new frame. This holds from IDLE, ACTIVE, or DONE.

## Timing
- Latency is 1 cycle: a pixel accepted at edge N gives blur and blur_valid valid from edge N until edge N+1.
- Throughput is one pixel per cycle; vb_en may stay high continuously.
- blur holds its last value when no pixel is accepted. blur_valid deasserts the cycle after an edge with no accept.
- frame_done is high for exactly the one cycle in which the last pixel's blur_valid is high.
- Reset values:
  - blur = 32'hff000000, blur_valid = 0, frame_done = 0.
  - State = IDLE; col and row = 0.
  - Line buffer contents are don't-care, since masking covers them.
- Reset asserted mid-frame: all of the above take effect at the next edge; the partial frame is discarded.
- vb_en low mid-row stalls the block; the counters and buffers hold.

## Test plan
Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4.
- Reset, then idle 2 cycles -> blur=32'hff000000, blur_valid=0, frame_done=0. vb_en pulses before frame_start -> no blur_valid.
- frame_start, mode 3'b101, 16 pixels of 32'hffffffff with continuous vb_en:
  - row 0 outputs ff3f3f3f, row 1 ff7f7f7f, row 2 ffbfbfbf, row 3 ffffffff;
  - frame_done is high only with the 16th blur_valid.
- Mode 3'b000, data 32'h12345678 -> blur=32'h12345678 one cycle after the accept.
- Blur mode, rows 0..3 of column 0 = 00040404, 00080808, 000c0c0c, 00101010 -> column-0 output in row 3 is ff0a0a0a (sum 40 >> 2 = 10).
- Accept 6 pixels, pulse frame_start together with vb_en on pixel ffffffff -> output ff3f3f3f (treated as row 0) and no frame_done for the aborted frame.
- Assert rst for one cycle mid-row 2 -> next cycle blur=32'hff000000, blur_valid=0; subsequent vb_en is ignored until frame_start.
